// File: rtl/mandel_render.sv
`default_nettype none
// ============================================================================
// mandel_render : raster-order pixel scheduler feeding one Mandelbrot engine
//                 and writing iteration counts to a framebuffer port.
// Revision      : 1.0
// ============================================================================
module mandel_render #(
   parameter int H_RES = 320,
   parameter int V_RES = 180,
   parameter int ITERW = 8,
   parameter int ADDRW = $clog2(H_RES*V_RES),
   parameter int CORDW = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CORDW-1:0] x_start,
   input  logic [CORDW-1:0] y_start,
   input  logic [CORDW-1:0] step,
   output logic             calc_start,
   output logic [CORDW-1:0] calc_re,
   output logic [CORDW-1:0] calc_im,
   input  logic             calc_done,
   input  logic [ITERW-1:0] calc_iter,
   output logic             fb_we,
   output logic [ADDRW-1:0] fb_addr,
   output logic [ITERW-1:0] fb_data,
   input  logic             fb_ready,
   output logic             busy,
   output logic             frame_done
);

   localparam int COLW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int ROWW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [COLW-1:0] COL_LAST = COLW'(H_RES - 1);
   localparam logic [ROWW-1:0] ROW_LAST = ROWW'(V_RES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CORDW-1:0] x0, x0_nxt;
   logic [CORDW-1:0] stp, stp_nxt;
   logic [CORDW-1:0] re_nxt, im_nxt;
   logic [COLW-1:0]  col, col_nxt;
   logic [ROWW-1:0]  row, row_nxt;
   logic [ADDRW-1:0] addr_nxt;
   logic [ITERW-1:0] data_nxt;
   logic             calc_start_nxt, fb_we_nxt, busy_nxt, frame_done_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         x0         <= '0;
         stp        <= '0;
         col        <= '0;
         row        <= '0;
         calc_start <= 1'b0;
         calc_re    <= '0;
         calc_im    <= '0;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         x0         <= x0_nxt;
         stp        <= stp_nxt;
         col        <= col_nxt;
         row        <= row_nxt;
         calc_start <= calc_start_nxt;
         calc_re    <= re_nxt;
         calc_im    <= im_nxt;
         fb_we      <= fb_we_nxt;
         fb_addr    <= addr_nxt;
         fb_data    <= data_nxt;
         busy       <= busy_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      x0_nxt         = x0;
      stp_nxt        = stp;
      col_nxt        = col;
      row_nxt        = row;
      re_nxt         = calc_re;
      im_nxt         = calc_im;
      addr_nxt       = fb_addr;
      data_nxt       = fb_data;
      fb_we_nxt      = fb_we;
      busy_nxt       = busy;
      calc_start_nxt = 1'b0;
      frame_done_nxt = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               x0_nxt         = x_start;
               stp_nxt        = step;
               re_nxt         = x_start;
               im_nxt         = y_start;
               col_nxt        = '0;
               row_nxt        = '0;
               addr_nxt       = '0;
               busy_nxt       = 1'b1;
               calc_start_nxt = 1'b1;
               state_nxt      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (calc_done) begin
               data_nxt  = calc_iter;
               fb_we_nxt = 1'b1;
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            if (fb_ready) begin
               fb_we_nxt = 1'b0;
               if (col != COL_LAST) begin
                  col_nxt        = col + COLW'(1);
                  re_nxt         = calc_re + stp;
                  addr_nxt       = fb_addr + ADDRW'(1);
                  calc_start_nxt = 1'b1;
                  state_nxt      = S_ISSUE;
               end else if (row != ROW_LAST) begin
                  // Imaginary axis runs downward, so each new line subtracts step.
                  col_nxt        = '0;
                  row_nxt        = row + ROWW'(1);
                  re_nxt         = x0;
                  im_nxt         = calc_im - stp;
                  addr_nxt       = fb_addr + ADDRW'(1);
                  calc_start_nxt = 1'b1;
                  state_nxt      = S_ISSUE;
               end else begin
                  busy_nxt       = 1'b0;
                  frame_done_nxt = 1'b1;
                  state_nxt      = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mandel_render.sv
`default_nettype none
// ============================================================================
// tb_mandel_render : scoreboard bench for mandel_render on a 4x3 frame.
// Revision         : 1.0
// ============================================================================
module tb_mandel_render;

   localparam int H     = 4;
   localparam int V     = 3;
   localparam int ITERW = 8;
   localparam int CORDW = 25;
   localparam int ADDRW = $clog2(H*V);

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CORDW-1:0] x_start, y_start, step;
   logic             calc_start;
   logic [CORDW-1:0] calc_re, calc_im;
   logic             calc_done;
   logic [ITERW-1:0] calc_iter;
   logic             fb_we;
   logic [ADDRW-1:0] fb_addr;
   logic [ITERW-1:0] fb_data;
   logic             fb_ready = 1'b1;
   logic             busy, frame_done;

   mandel_render #(
      .H_RES(H), .V_RES(V), .ITERW(ITERW), .ADDRW(ADDRW), .CORDW(CORDW)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .x_start(x_start), .y_start(y_start), .step(step),
      .calc_start(calc_start), .calc_re(calc_re), .calc_im(calc_im),
      .calc_done(calc_done), .calc_iter(calc_iter),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard queues: filled when a frame is started, drained by the monitor.
   int               exp_addr[$];
   int               exp_data[$];
   logic [CORDW-1:0] exp_re[$];
   logic [CORDW-1:0] exp_im[$];

   int wr_cnt     = 0;
   int fd_cnt     = 0;
   int frame_id   = 0;
   int stall_addr = -1;
   int stall_left = 0;

   // Engine model: answers each calc_start with iter = issue index in frame.
   logic             eng_done  = 1'b0;
   logic             spur_done = 1'b0;
   logic [ITERW-1:0] eng_iter  = '0;
   logic [ITERW-1:0] spur_iter = '0;
   int               eng_cnt   = 0;
   int               eng_id    = 0;
   int               eng_issue = 0;
   logic [ITERW-1:0] eng_pend  = '0;

   assign calc_done = eng_done | spur_done;
   assign calc_iter = spur_done ? spur_iter : eng_iter;

   initial begin
      forever begin
         @(negedge clk);
         eng_done = 1'b0;
         if (rst) begin
            eng_cnt = 0;
         end else if (calc_start) begin
            if (frame_id != eng_id) begin
               eng_id    = frame_id;
               eng_issue = 0;
            end
            eng_pend = ITERW'(eng_issue);
            eng_issue++;
            eng_cnt = 5;
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               eng_done = 1'b1;
               eng_iter = eng_pend;
            end
         end
      end
   end

   // Monitor: drives fb_ready back-pressure and checks every output event.
   logic             holding = 1'b0;
   logic             prev_fd = 1'b0;
   logic [ADDRW-1:0] hold_addr = '0;
   logic [ITERW-1:0] hold_data = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (fb_we && int'(fb_addr) == stall_addr && stall_left > 0) begin
            fb_ready = 1'b0;
            stall_left--;
         end else begin
            fb_ready = 1'b1;
         end
         if (holding && !rst) begin
            check("bp_we_held", 32'(fb_we), 32'd1);
            check("bp_addr_held", 32'(fb_addr), 32'(hold_addr));
            check("bp_data_held", 32'(fb_data), 32'(hold_data));
         end
         holding   = fb_we && !fb_ready;
         hold_addr = fb_addr;
         hold_data = fb_data;
         if (fb_we) check("no_issue_in_write", 32'(calc_start), 32'd0);
         if (calc_start) begin
            if (exp_re.size() == 0) begin
               check("unexpected_issue", 32'(calc_start), 32'd0);
            end else begin
               check("issue_re", 32'(calc_re), 32'(exp_re.pop_front()));
               check("issue_im", 32'(calc_im), 32'(exp_im.pop_front()));
            end
         end
         if (fb_we && fb_ready) begin
            wr_cnt++;
            if (exp_addr.size() == 0) begin
               check("unexpected_write", 32'(fb_we), 32'd0);
            end else begin
               check("wr_addr", 32'(fb_addr), 32'(exp_addr.pop_front()));
               check("wr_data", 32'(fb_data), 32'(exp_data.pop_front()));
            end
         end
         if (frame_done) begin
            fd_cnt++;
            check("fd_pulse_len", 32'(prev_fd), 32'd0);
            check("fd_busy_low", 32'(busy), 32'd0);
            check("fd_writes_left", 32'(exp_addr.size()), 32'd0);
         end
         prev_fd = frame_done;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_calc_start"}, 32'(calc_start), 32'd0);
      check({tag, "_calc_re"},    32'(calc_re),    32'd0);
      check({tag, "_calc_im"},    32'(calc_im),    32'd0);
      check({tag, "_fb_we"},      32'(fb_we),      32'd0);
      check({tag, "_fb_addr"},    32'(fb_addr),    32'd0);
      check({tag, "_fb_data"},    32'(fb_data),    32'd0);
      check({tag, "_busy"},       32'(busy),       32'd0);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   task automatic start_frame(input logic [CORDW-1:0] x, input logic [CORDW-1:0] y,
                              input logic [CORDW-1:0] s);
      frame_id++;
      for (int r = 0; r < V; r++) begin
         for (int c = 0; c < H; c++) begin
            exp_addr.push_back(r*H + c);
            exp_data.push_back((r*H + c) % 256);
            exp_re.push_back(x + CORDW'(c) * s);
            exp_im.push_back(y - CORDW'(r) * s);
         end
      end
      @(posedge clk); #1;
      start = 1'b1; x_start = x; y_start = y; step = s;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("start_issue_latency", 32'(calc_start), 32'd1);
      check("start_busy", 32'(busy), 32'd1);
   endtask

   task automatic wait_frame(input int w0, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (frame_done) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_frame_done_seen"}, 32'(ok), 32'd1);
      check({tag, "_write_count"}, 32'(wr_cnt - w0), 32'(H*V));
   endtask

   initial begin
      int  w0, f0;
      bit  found;
      rst = 1'b1; start = 1'b0;
      x_start = '0; y_start = '0; step = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic frame: re from -2.0, im from +1.0, step 0.5.
      w0 = wr_cnt; f0 = fd_cnt;
      start_frame(25'h1C00000, 25'h0200000, 25'h0100000);
      wait_frame(w0, "basic");
      repeat (5) @(negedge clk);
      check("basic_fd_once", 32'(fd_cnt - f0), 32'd1);

      // Back-pressure on pixel 2.
      stall_addr = 2; stall_left = 7;
      w0 = wr_cnt;
      start_frame(25'h1C00000, 25'h0200000, 25'h0100000);
      wait_frame(w0, "bp");
      check("bp_stall_consumed", 32'(stall_left), 32'd0);
      stall_addr = -1;

      // Spurious start mid-frame, then spurious calc_done during ISSUE.
      w0 = wr_cnt;
      start_frame(25'h1E00000, 25'h0100000, 25'h0040000);
      repeat (3) @(posedge clk);
      #1 start = 1'b1; x_start = 25'h0AAAAAA; y_start = 25'h0555555; step = 25'h0001111;
      @(posedge clk); #1 start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (calc_start) begin
            found = 1'b1;
            break;
         end
      end
      check("spur_issue_found", 32'(found), 32'd1);
      spur_iter = 8'hEE; spur_done = 1'b1;
      @(negedge clk) spur_done = 1'b0;
      wait_frame(w0, "spur");

      // Reset while stalled in WRITE at addr 6.
      stall_addr = 6; stall_left = 100000;
      start_frame(25'h0300000, 25'h1F00000, 25'h0080000);
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (fb_we && fb_addr == ADDRW'(6)) begin
            found = 1'b1;
            break;
         end
      end
      check("rst_write6_found", 32'(found), 32'd1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst_mid");
      exp_addr.delete(); exp_data.delete(); exp_re.delete(); exp_im.delete();
      stall_left = 0; stall_addr = -1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      w0 = wr_cnt;
      @(negedge clk);
      spur_iter = 8'h77; spur_done = 1'b1;
      @(negedge clk) spur_done = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_no_late_write", 32'(wr_cnt - w0), 32'd0);
      check("rst_busy_low", 32'(busy), 32'd0);
      w0 = wr_cnt;
      start_frame(25'h0300000, 25'h1F00000, 25'h0080000);
      wait_frame(w0, "rst_restart");

      // Wrap: re crosses from max positive into negative.
      w0 = wr_cnt;
      start_frame(25'h0FFFFFF, 25'h0000000, 25'h0000001);
      wait_frame(w0, "wrap");

      // Back-to-back: start in the cycle right after frame_done.
      w0 = wr_cnt;
      start_frame(25'h1D00000, 25'h0180000, 25'h0020000);
      wait_frame(w0, "b2b_first");
      w0 = wr_cnt;
      start_frame(25'h0123456, 25'h1ABCDEF, 25'h0003000);
      wait_frame(w0, "b2b_second");

      repeat (5) @(negedge clk);
      check("final_queue_empty", 32'(exp_re.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
